prs_checker: RTL and testbench

Self-synchronising pseudo-random sequence checker: the receive-side counterpart of `prs_gen`. It sits after the `fano_decoder` symbol outputs (`test_dec_sym` / `test_dec_vld`). It locks onto the PRBS-15 (x^15 + x^14 + 1) stream that `prs_gen` produces, then counts bit errors, total checked bits, per-window error counts, and loss-of-lock events. Its counters give BER figures for the decoder in simulation and on hardware.

---
 rtl/prs_checker.sv | 182 ++++++++++++++++++
 tb/tb_prs_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prs_checker.sv
// prs_checker: self-synchronising PRBS-15 (x^15 + x^14 + 1) sequence checker.
// It sits behind the decoder's symbol outputs. In SEARCH it loads received
// symbols into a 15-bit state register and locks once LOCK_MATCHES
// consecutive predictions are correct. In LOCK the state register runs freely
// and is never fed by the input. The checker counts checked symbols, errored
// symbols, per-window errors and LOCK->SEARCH transitions.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   i_vld        input symbol strobe (single-cycle, arbitrary gaps)
//   i_sym        decoded symbol
//   i_win_len    window length in symbols (0 = window evaluation disabled)
//   i_loss_thr   lock is lost when window errors > this value
//   i_clear      synchronous clear of o_bit_cnt / o_err_cnt / o_relock_cnt
//   o_lock       checker locked
//   o_bit_cnt    symbols checked while locked (saturating)
//   o_err_cnt    errored symbols while locked (saturating)
//   o_win_err    error count of the last completed window
//   o_win_vld    one-cycle pulse when o_win_err updates
//   o_relock_cnt number of LOCK->SEARCH transitions (saturating)
module prs_checker #(
  parameter int LOCK_MATCHES = 64,
  parameter int WIN_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_vld,
  input  logic                 i_sym,
  input  logic [WIN_WIDTH-1:0] i_win_len,
  input  logic [WIN_WIDTH-1:0] i_loss_thr,
  input  logic                 i_clear,
  output logic                 o_lock,
  output logic [CNT_WIDTH-1:0] o_bit_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic [WIN_WIDTH-1:0] o_win_err,
  output logic                 o_win_vld,
  output logic [15:0]          o_relock_cnt
);

  localparam logic [15:0] LOCK_TGT = 16'(LOCK_MATCHES);

  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [14:0]          s_q, s_d;
  logic [3:0]           fill_q, fill_d;
  logic [15:0]          match_q, match_d;
  logic [WIN_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_WIDTH-1:0] win_acc_q, win_acc_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [WIN_WIDTH-1:0] win_err_q, win_err_d;
  logic                 win_vld_q, win_vld_d;
  logic [15:0]          relock_q, relock_d;

  logic                 exp_bit;
  logic                 err;
  logic                 win_close;
  logic [WIN_WIDTH-1:0] win_acc_nx;

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  function automatic logic [WIN_WIDTH-1:0] sat_win(input logic [WIN_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + WIN_WIDTH'(1) : v;
  endfunction

  function automatic logic [15:0] sat_16(input logic [15:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_acc_d = win_acc_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    win_err_d = win_err_q;
    win_vld_d = 1'b0;
    relock_d  = relock_q;

    exp_bit    = s_q[14] ^ s_q[13];
    err        = i_sym ^ exp_bit;
    win_acc_nx = sat_win(win_acc_q, err);
    win_close  = (i_win_len != '0) && (win_cnt_q == i_win_len - WIN_WIDTH'(1));

    if (i_vld) begin
      case (state_q)
        SEARCH: begin
          s_d = {s_q[13:0], i_sym};
          if (fill_q != 4'd15) begin
            fill_d = fill_q + 4'd1;
          end else if ((s_q == '0) || err) begin
            // An all-zero register predicts zeros forever; never count it as a match.
            match_d = '0;
          end else begin
            match_d = match_q + 16'd1;
            if (match_d == LOCK_TGT) begin
              state_d   = LOCK;
              match_d   = '0;
              win_cnt_d = '0;
              win_acc_d = '0;
            end
          end
        end
        LOCK: begin
          // Free-running: received errors never enter the state register.
          s_d       = {s_q[13:0], exp_bit};
          bit_cnt_d = sat_cnt(bit_cnt_q, 1'b1);
          err_cnt_d = sat_cnt(err_cnt_q, err);
          if (win_close) begin
            win_err_d = win_acc_nx;
            win_vld_d = 1'b1;
            win_cnt_d = '0;
            win_acc_d = '0;
            if (win_acc_nx > i_loss_thr) begin
              state_d  = SEARCH;
              fill_d   = '0;
              match_d  = '0;
              relock_d = sat_16(relock_q, 1'b1);
            end
          end else begin
            // Wraps at all-ones if i_win_len shrank below the current count.
            win_cnt_d = win_cnt_q + WIN_WIDTH'(1);
            win_acc_d = win_acc_nx;
          end
        end
      endcase
    end

    // Clear wins over any increment in the same cycle.
    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      relock_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      s_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_acc_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      win_err_q <= '0;
      win_vld_q <= 1'b0;
      relock_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_acc_q <= win_acc_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      win_err_q <= win_err_d;
      win_vld_q <= win_vld_d;
      relock_q  <= relock_d;
    end
  end

  assign o_lock       = (state_q == LOCK);
  assign o_bit_cnt    = bit_cnt_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_win_err    = win_err_q;
  assign o_win_vld    = win_vld_q;
  assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_prs_checker.sv
// Bench for prs_checker: a PRBS-15 source model drives directed phases;
// expectations are queued ahead of the symbols and checked by a monitor.
module tb_prs_checker;
  localparam int WW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_vld = 1'b0;
  logic          i_sym = 1'b0;
  logic          i_clear = 1'b0;
  logic [WW-1:0] i_win_len = '0;
  logic [WW-1:0] i_loss_thr = '0;
  logic          o_lock;
  logic [CW-1:0] o_bit_cnt;
  logic [CW-1:0] o_err_cnt;
  logic [WW-1:0] o_win_err;
  logic          o_win_vld;
  logic [15:0]   o_relock_cnt;

  prs_checker #(.LOCK_MATCHES(64), .WIN_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_vld(i_vld), .i_sym(i_sym),
    .i_win_len(i_win_len), .i_loss_thr(i_loss_thr), .i_clear(i_clear),
    .o_lock(o_lock), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt),
    .o_win_err(o_win_err), .o_win_vld(o_win_vld), .o_relock_cnt(o_relock_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        lock;
    logic [31:0] bits;
    logic [31:0] errs;
    logic [31:0] rel;
  } st_exp_t;

  st_exp_t     exp_q[$];
  logic [31:0] win_q[$];
  int          checks = 0;
  int          failures = 0;
  int          sym_idx = 0;
  int          st_idx = 0;
  logic [14:0] g = 15'h0001;
  event        imm_ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference PRBS-15 source.
  task automatic next_bit(output logic b);
    b = g[14] ^ g[13];
    g = {g[13:0], b};
  endtask

  task automatic send(input logic s, input logic clr, input int gap);
    i_sym   = s;
    i_clear = clr;
    i_vld   = 1'b1;
    @(negedge clk);
    i_vld   = 1'b0;
    i_clear = 1'b0;
    repeat (gap - 1) @(negedge clk);
    st_idx++;
  endtask

  task automatic clean(input int n, input int gap);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      send(b, 1'b0, gap);
    end
  endtask

  task automatic push_at(input int off, input logic lock, input int bits,
                         input int errs, input int rel);
    st_exp_t e;
    e.idx  = st_idx + off;
    e.lock = lock;
    e.bits = bits;
    e.errs = errs;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1 -> imm_ev;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(posedge clk) if (i_vld) sym_idx <= sym_idx + 1;

  // Monitor: window reports and per-symbol state checkpoints.
  initial begin
    logic    pend_pulse;
    st_exp_t e;
    logic [31:0] w;
    pend_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_pulse) begin
        check("win_vld_one_cycle", 32'(o_win_vld), 32'd0);
        pend_pulse = 1'b0;
      end
      if (o_win_vld) begin
        if (win_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_win_vld: got win_err %0d expected no window", o_win_err);
        end else begin
          w = win_q.pop_front();
          check("win_err", 32'(o_win_err), w);
          pend_pulse = 1'b1;
        end
      end
      while (exp_q.size() > 0 && exp_q[0].idx == sym_idx) begin
        e = exp_q.pop_front();
        check($sformatf("lock@%0d", e.idx), 32'(o_lock), 32'(e.lock));
        check($sformatf("bit_cnt@%0d", e.idx), o_bit_cnt, e.bits);
        check($sformatf("err_cnt@%0d", e.idx), o_err_cnt, e.errs);
        check($sformatf("relock_cnt@%0d", e.idx), 32'(o_relock_cnt), e.rel);
      end
    end
  end

  // Immediate checks while reset is held: everything must read zero.
  initial begin
    forever begin
      @(imm_ev);
      check("rst_lock", 32'(o_lock), 32'd0);
      check("rst_bit_cnt", o_bit_cnt, 32'd0);
      check("rst_err_cnt", o_err_cnt, 32'd0);
      check("rst_win_err", 32'(o_win_err), 32'd0);
      check("rst_win_vld", 32'(o_win_vld), 32'd0);
      check("rst_relock_cnt", 32'(o_relock_cnt), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic b;
    int   z;
    int   t;
    i_win_len  = 16'd100;
    i_loss_thr = 16'd10;
    repeat (3) @(negedge clk);
    -> imm_ev;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean stream: lock at symbol 79, then 1000 clean symbols in 10 windows.
    push_at(78, 1'b0, 0, 0, 0);
    push_at(79, 1'b1, 0, 0, 0);
    for (int k = 0; k < 10; k++) win_q.push_back(32'd0);
    push_at(1079, 1'b1, 1000, 0, 0);
    clean(279, 64);
    for (int i = 0; i < 800; i++) begin
      next_bit(b);
      send(b, 1'b0, (i % 4) + 1);
    end

    // One inverted symbol inside a 100-symbol window: one error, lock held.
    push_at(51, 1'b1, 1051, 1, 0);
    push_at(100, 1'b1, 1100, 1, 0);
    win_q.push_back(32'd1);
    clean(50, 2);
    next_bit(b);
    send(~b, 1'b0, 2);
    clean(49, 2);

    // Constant-one input over a 1000-symbol window: lock lost.
    i_win_len  = 16'd1000;
    i_loss_thr = 16'd100;
    z = 0;
    for (int i = 0; i < 1000; i++) begin
      next_bit(b);
      if (!b) z++;
      if (i == 999) begin
        win_q.push_back(32'(z));
        push_at(1, 1'b0, 2100, 1 + z, 1);
      end
      send(1'b1, 1'b0, 1);
    end

    // Clean stream resumes: relock after 15 + 64 symbols.
    i_win_len = 16'd0;
    push_at(78, 1'b0, 2100, 1 + z, 1);
    push_at(79, 1'b1, 2100, 1 + z, 1);
    clean(79, 1);

    // Clear together with a symbol, then one more symbol.
    push_at(1, 1'b1, 0, 0, 0);
    push_at(2, 1'b1, 1, 0, 0);
    next_bit(b);
    send(b, 1'b1, 1);
    clean(1, 1);

    // Asynchronous reset mid-lock, then relock with clean-stream latency.
    push_at(20, 1'b1, 21, 0, 0);
    clean(20, 3);
    async_reset();
    push_at(78, 1'b0, 0, 0, 0);
    push_at(79, 1'b1, 0, 0, 0);
    clean(79, 2);

    // All-zero input from reset never locks.
    async_reset();
    for (int k = 1; k <= 10; k++) push_at(k * 1000, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10000; i++) send(1'b0, 1'b0, 1);

    t = 0;
    while ((exp_q.size() > 0 || win_q.size() > 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0 || win_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d state and %0d window expectations pending expected 0",
               exp_q.size(), win_q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
